// File: rtl/codificador_pkg.sv
// codificador_pkg: shared FSM states, debounce default and the 8-line priority encoder
package codificador_pkg;

    localparam int DEBOUNCE_DEF = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } estado_t;

    typedef struct packed {
        logic       any;
        logic [2:0] idx;
    } enc_t;

    // Active-low lines in, lowest pressed index wins; any=0 means nothing pressed.
    function automatic enc_t prio_enc(input logic [7:0] b_n);
        enc_t r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (!b_n[i]) begin
                r.any = 1'b1;
                r.idx = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sincronizador.sv
// sincronizador: two-flop synchronizer, resets to all ones (released keys)
module sincronizador #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q, s2_q;

    // Two back-to-back flops to tame metastability on the raw key lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/codificador_prioridad_antirrebote.sv
// codificador_prioridad_antirrebote: debounced 8-key priority encoder with valid strobe and held flag.
// Optional macro ECHO_ANODE_EN adds a registered active-low one-hot echo an_n of the held key.
module codificador_prioridad_antirrebote
    import codificador_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] btn_n,
`ifdef ECHO_ANODE_EN
    output logic [7:0] an_n,
`endif
    output logic [2:0] code,
    output logic       valid,
    output logic       held
);

    localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0] sync_q;
    enc_t       enc_q;
    estado_t    state_q, state_d;
    logic [7:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0] cand_q, cand_d;
    logic [2:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       held_q, held_d;

    sincronizador #(.W(8)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (btn_n),
        .q_o   (sync_q)
    );

    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    // Next-state logic: debounce a press, accept once, then debounce the release.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
        unique case (state_q)
            IDLE: begin
                if (enc_q.any) begin
                    cand_d  = enc_q.idx;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!enc_q.any || enc_q.idx != cand_q) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == LAST) begin
                    code_d  = cand_q;
                    valid_d = 1'b1;
                    held_d  = 1'b1;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                if (!enc_q.any) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (enc_q.any) begin
                    cnt_d   = '0;
                    state_d = HELD;
                end else if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    held_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Encoder register plus FSM state, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_q   <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            enc_q   <= prio_enc(sync_q);
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    assign code  = code_q;
    assign valid = valid_q;
    assign held  = held_q;

`ifdef ECHO_ANODE_EN
    logic [7:0] an_n_q;

    // Echo register built from next-state so it moves together with held and code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) an_n_q <= 8'hFF;
        else        an_n_q <= held_d ? ~(8'd1 << code_d) : 8'hFF;
    end

    assign an_n = an_n_q;
`endif

endmodule

// File: tb/tb_codificador_prioridad_antirrebote.sv
// tb_codificador_prioridad_antirrebote: directed checks of debounce, priority, release and reset
module tb_codificador_prioridad_antirrebote;
    import codificador_pkg::*;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] btn_n = 8'hFF;
    logic [2:0] code;
    logic       valid;
    logic       held;
`ifdef ECHO_ANODE_EN
    logic [7:0] an_n;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int lat, pulses;

    codificador_prioridad_antirrebote #(.DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_n),
`ifdef ECHO_ANODE_EN
        .an_n  (an_n),
`endif
        .code  (code),
        .valid (valid),
        .held  (held)
    );

    always #5 clk = ~clk;

    // Drive pat at a negedge, then watch ncyc edges; lat is the edge index of the first valid.
    task automatic drive(input logic [7:0] pat, input int ncyc, input bit rel_rst,
                         output int l, output int p);
        l = -1;
        p = 0;
        @(negedge clk);
        btn_n = pat;
        if (rel_rst) rst_n = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                if (l < 0) l = i;
                p++;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        btn_n = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (code !== 3'd0) begin n_bad++; $display("FAIL reset_code got %0d want 0", code); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", valid); end
        n_cmp++; if (held !== 1'b0) begin n_bad++; $display("FAIL reset_held got %b want 0", held); end
        n_cmp++; if (dut.sync_q !== 8'hFF) begin n_bad++; $display("FAIL reset_sync got %h want ff", dut.sync_q); end
        n_cmp++; if (dut.state_q !== IDLE) begin n_bad++; $display("FAIL reset_state got %0d want IDLE", dut.state_q); end
`ifdef ECHO_ANODE_EN
        n_cmp++; if (an_n !== 8'hFF) begin n_bad++; $display("FAIL reset_an got %h want ff", an_n); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        drive(8'b1111_1011, 20, 1'b0, lat, pulses);
        n_cmp++; if (lat !== D + 3) begin n_bad++; $display("FAIL single_latency got %0d want %0d", lat, D + 3); end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL single_pulses got %0d want 1", pulses); end
        n_cmp++; if (code !== 3'd2) begin n_bad++; $display("FAIL single_code got %0d want 2", code); end
        n_cmp++; if (held !== 1'b1) begin n_bad++; $display("FAIL single_held got %b want 1", held); end
    endtask

    task automatic test_held_ignore;
        drive(8'b1111_1110, 10, 1'b0, lat, pulses);
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL ignore_pulses got %0d want 0", pulses); end
        n_cmp++; if (code !== 3'd2) begin n_bad++; $display("FAIL ignore_code got %0d want 2", code); end
    endtask

    task automatic test_release_repress;
        drive(8'hFF, 2, 1'b0, lat, pulses);
        drive(8'b1111_1011, 10, 1'b0, lat, pulses);
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL repress_pulses got %0d want 0", pulses); end
        n_cmp++; if (held !== 1'b1) begin n_bad++; $display("FAIL repress_held got %b want 1", held); end
        drive(8'hFF, 10, 1'b0, lat, pulses);
        n_cmp++; if (held !== 1'b0) begin n_bad++; $display("FAIL release_held got %b want 0", held); end
        n_cmp++; if (code !== 3'd2) begin n_bad++; $display("FAIL release_code got %0d want 2", code); end
        drive(8'b1011_1111, 20, 1'b0, lat, pulses);
        n_cmp++; if (lat !== D + 3) begin n_bad++; $display("FAIL key6_latency got %0d want %0d", lat, D + 3); end
        n_cmp++; if (code !== 3'd6) begin n_bad++; $display("FAIL key6_code got %0d want 6", code); end
        drive(8'hFF, 10, 1'b0, lat, pulses);
    endtask

    task automatic test_bounce;
        int tot;
        tot = 0;
        for (int k = 0; k < 3; k++) begin
            drive(8'b1111_0111, 2, 1'b0, lat, pulses);
            tot += pulses;
            drive(8'hFF, 2, 1'b0, lat, pulses);
            tot += pulses;
        end
        drive(8'hFF, 10, 1'b0, lat, pulses);
        tot += pulses;
        n_cmp++; if (tot !== 0) begin n_bad++; $display("FAIL bounce_pulses got %0d want 0", tot); end
        n_cmp++; if (code !== 3'd6) begin n_bad++; $display("FAIL bounce_code got %0d want 6", code); end
        n_cmp++; if (held !== 1'b0) begin n_bad++; $display("FAIL bounce_held got %b want 0", held); end
        n_cmp++; if (dut.state_q !== IDLE) begin n_bad++; $display("FAIL bounce_state got %0d want IDLE", dut.state_q); end
    endtask

    task automatic test_priority;
        drive(8'b0110_1111, 20, 1'b0, lat, pulses);
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL prio_pulses got %0d want 1", pulses); end
        n_cmp++; if (code !== 3'd4) begin n_bad++; $display("FAIL prio_code got %0d want 4", code); end
        drive(8'hFF, 10, 1'b0, lat, pulses);
    endtask

    task automatic test_reset_mid;
        drive(8'b1111_1011, 6, 1'b0, lat, pulses);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (code !== 3'd0) begin n_bad++; $display("FAIL rstmid_code got %0d want 0", code); end
        n_cmp++; if (held !== 1'b0) begin n_bad++; $display("FAIL rstmid_held got %b want 0", held); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %b want 0", valid); end
        repeat (2) @(posedge clk);
        drive(8'b1111_1011, 20, 1'b1, lat, pulses);
        n_cmp++; if (lat !== D + 3) begin n_bad++; $display("FAIL rstmid_latency got %0d want %0d", lat, D + 3); end
        n_cmp++; if (code !== 3'd2) begin n_bad++; $display("FAIL rstmid_code2 got %0d want 2", code); end
        drive(8'hFF, 10, 1'b0, lat, pulses);
    endtask

`ifdef ECHO_ANODE_EN
    task automatic test_echo;
        drive(8'b1101_1111, 20, 1'b0, lat, pulses);
        n_cmp++; if (an_n !== 8'b1101_1111) begin n_bad++; $display("FAIL echo_on got %b want 11011111", an_n); end
        drive(8'hFF, 10, 1'b0, lat, pulses);
        n_cmp++; if (an_n !== 8'hFF) begin n_bad++; $display("FAIL echo_off got %h want ff", an_n); end
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_held_ignore;
        test_release_repress;
        test_bounce;
        test_priority;
        test_reset_mid;
`ifdef ECHO_ANODE_EN
        test_echo;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
